internal_data_ram: RTL and testbench

- Word-organised, parameterised RAM slave on the shared CPU data bus (data_address / data_bus / data_cs / data_rw / data_mode).
- Serves as the stack / scratch RAM of the MIPS core.
- Claims only addresses inside its window; outside the window it stays electrically invisible (high-Z), so several slaves share one tri-state data_bus.
- Supports byte, halfword and word loads/stores with little-endian byte lanes.

---
 rtl/internal_data_ram.sv | 93 +++++++++
 tb/tb_internal_data_ram.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/internal_data_ram.sv
// rtl/internal_data_ram.sv - word-organised data RAM slave on the shared tri-state CPU data bus
module internal_data_ram #(
    parameter int unsigned  SIZE    = 4096,
    parameter logic [31:0]  ADDRESS = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_address,
    inout  wire  [31:0] data_bus,
    input  logic        data_cs,
    input  logic        data_rw,
    input  logic [1:0]  data_mode
);

    localparam int          IW      = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [32:0] WIN_LEN = 33'(SIZE) << 2;

    // Storage; not cleared by reset so the stack survives a core restart.
    logic [31:0]   mem_q [SIZE];

    logic [32:0]   rel;
    logic          hit;
    logic          aligned;
    logic          sel;
    logic [IW-1:0] idx;
    logic [1:0]    off;
    logic          rd_en;
    logic          wr_en;
    logic [3:0]    be_d;
    logic [31:0]   wr_data_d;
    logic [31:0]   rd_word;
    logic [31:0]   rd_shift;
    logic [31:0]   rd_data;

    // Window decode in 33 bits: an address below the base wraps to a huge
    // offset, and a window ending at 2^32 still compares correctly.
    always_comb begin
        rel = {1'b0, data_address} - {1'b0, ADDRESS};
        hit = data_cs && (rel < WIN_LEN);
        idx = rel[IW+1:2];
        off = rel[1:0];
    end

    // Natural alignment per access size; the reserved mode never matches.
    always_comb begin
        aligned = 1'b0;
        case (data_mode)
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = (off[0] == 1'b0);
            2'd2:    aligned = (off == 2'd0);
            default: aligned = 1'b0;
        endcase
        sel   = hit && aligned && !reset;
        rd_en = sel && !data_rw;
        wr_en = sel && data_rw;
    end

    // Store lane enables and bus data moved into its little-endian lanes.
    always_comb begin
        be_d = 4'b0000;
        case (data_mode)
            2'd0:    be_d = 4'b0001 << off;
            2'd1:    be_d = 4'b0011 << off;
            2'd2:    be_d = 4'b1111;
            default: be_d = 4'b0000;
        endcase
        wr_data_d = data_bus << {off, 3'b000};
    end

    // Zero-extended load; sign extension is left to the core.
    always_comb begin
        rd_word  = mem_q[idx];
        rd_shift = rd_word >> {off, 3'b000};
        rd_data  = 32'h0;
        case (data_mode)
            2'd0:    rd_data = {24'h0, rd_shift[7:0]};
            2'd1:    rd_data = {16'h0, rd_shift[15:0]};
            default: rd_data = rd_word;
        endcase
    end

    assign data_bus = rd_en ? rd_data : 32'bz;

    // Commit enabled byte lanes on the rising edge; reset blocks the store.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (!reset && wr_en && be_d[b]) begin
                mem_q[idx][8*b +: 8] <= wr_data_d[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_internal_data_ram.sv
// tb/tb_internal_data_ram.sv - directed and randomized bench for internal_data_ram with a byte-level model
module tb_internal_data_ram;

    localparam int unsigned SIZE = 4096;
    localparam logic [31:0] BASE = 32'hFFFF_BFF0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_address = 32'h0;
    wire  [31:0] data_bus;
    logic        data_cs = 1'b0;
    logic        data_rw = 1'b0;
    logic [1:0]  data_mode = 2'd2;
    logic        tb_drv = 1'b0;
    logic [31:0] tb_dat = 32'h0;

    int tests = 0;
    int fails = 0;

    logic [7:0] model_bytes [longint];

    assign data_bus = tb_drv ? tb_dat : 32'bz;

    always #5 clk = ~clk;

    internal_data_ram #(.SIZE(SIZE), .ADDRESS(BASE)) dut (
        .clk(clk), .reset(reset), .data_address(data_address), .data_bus(data_bus),
        .data_cs(data_cs), .data_rw(data_rw), .data_mode(data_mode)
    );

    function automatic bit m_sel(input logic [31:0] a, input logic cs, input logic [1:0] m, input logic rst);
        longint la = longint'(a);
        bit inwin = (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * longint'(SIZE));
        bit al = (m == 0) || (m == 1 && la % 2 == 0) || (m == 2 && la % 4 == 0);
        return cs && inwin && al && !rst;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, input logic cs, input logic [1:0] m, input logic rst);
        logic [31:0] r = 32'h0;
        if (!m_sel(a, cs, m, rst)) return 32'bz;
        for (int i = 0; i < (1 << m); i++) begin
            longint k = longint'(a) + i;
            r = r | (model_bytes.exists(k) ? (32'(model_bytes[k]) << (8 * i)) : 32'h0);
        end
        return r;
    endfunction

    task automatic m_write(input logic [31:0] a, input logic cs, input logic [1:0] m, input logic [31:0] d, input logic rst);
        if (!m_sel(a, cs, m, rst)) return;
        for (int i = 0; i < (1 << m); i++)
            model_bytes[longint'(a) + i] = 8'((d >> (8 * i)) & 32'hFF);
    endtask

    // One bus cycle: drive at negedge, check reads 1ns later, writes commit at posedge.
    task automatic access(input string tag, input logic [31:0] a, input logic rw, input logic [1:0] m,
                          input logic [31:0] d, input logic cs, input logic rst);
        logic [31:0] exp;
        @(negedge clk);
        data_address = a; data_rw = rw; data_mode = m; data_cs = cs; reset = rst;
        tb_drv = rw; tb_dat = d;
        #1;
        if (!rw) begin
            exp = m_read(a, cs, m, rst);
            tests++;
            assert (data_bus === exp) else begin
                fails++;
                $error("FAIL %s addr=%h mode=%0d got=%h exp=%h", tag, a, m, data_bus, exp);
            end
        end
        @(posedge clk);
        if (rw) m_write(a, cs, m, d, rst);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [1:0] m);
        access(tag, a, 1'b0, m, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [1:0] m, input logic [31:0] d);
        access("wr", a, 1'b1, m, d, 1'b1, 1'b0);
    endtask

    initial begin
        logic [31:0] pool [16];
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  m;
        logic        rw;
        logic        rst;

        // Reset state: bus released even with a selected read in flight.
        access("reset_hiz", BASE, 1'b0, 2'd2, 32'h0, 1'b1, 1'b1);
        access("reset_hiz2", BASE, 1'b0, 2'd2, 32'h0, 1'b1, 1'b1);

        wr(BASE, 2'd2, 32'hDEAD_BEEF);
        rd("word_rd", BASE, 2'd2);

        wr(32'hFFFF_C000, 2'd0, 32'h11);
        wr(32'hFFFF_C001, 2'd0, 32'h22);
        wr(32'hFFFF_C002, 2'd0, 32'h33);
        wr(32'hFFFF_C003, 2'd0, 32'h44);
        rd("bytes_word", 32'hFFFF_C000, 2'd2);
        rd("byte_off2", 32'hFFFF_C002, 2'd0);
        rd("half_off2", 32'hFFFF_C002, 2'd1);

        wr(32'hFFFF_C004, 2'd2, 32'hFFFF_FFFF);
        wr(32'hFFFF_C006, 2'd1, 32'h1234);
        rd("half_merge", 32'hFFFF_C004, 2'd2);

        wr(32'hFFFF_BFEC, 2'd2, 32'h5555_5555);
        rd("below_base", 32'hFFFF_BFEC, 2'd2);
        rd("base_kept", BASE, 2'd2);
        wr(32'hFFFF_FFF0, 2'd2, 32'h6666_6666);
        rd("past_end", 32'hFFFF_FFF0, 2'd2);
        wr(32'hFFFF_FFEC, 2'd2, 32'hA5A5_5A5A);
        rd("last_word", 32'hFFFF_FFEC, 2'd2);
        rd("last_byte", 32'hFFFF_FFEF, 2'd0);

        wr(BASE + 1, 2'd2, 32'h0);
        wr(BASE + 3, 2'd1, 32'h0);
        rd("misalign_kept", BASE, 2'd2);
        rd("misalign_rd", BASE + 1, 2'd2);
        rd("mode3_rd", BASE, 2'd3);
        wr(BASE, 2'd3, 32'h0);
        rd("mode3_nowr", BASE, 2'd2);

        access("rst_wr", BASE, 1'b1, 2'd2, 32'hCAFE_F00D, 1'b1, 1'b1);
        access("rst_rd", BASE, 1'b0, 2'd2, 32'h0, 1'b1, 1'b1);
        rd("after_rst", BASE, 2'd2);

        access("cs0_a", BASE, 1'b0, 2'd2, 32'h0, 1'b0, 1'b0);
        access("cs0_b", 32'hFFFF_C000, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        access("cs0_c", 32'h1234_5678, 1'b0, 2'd1, 32'h0, 1'b0, 1'b0);

        wr(BASE, 2'd2, 32'h0BAD_F00D);
        rd("back_to_back", BASE, 2'd2);

        // Randomized traffic over words near both window edges plus just outside.
        for (int i = 0; i < 16; i++) begin
            pool[i] = (i < 8) ? BASE + 32'(4 * i) : 32'hFFFF_FFF0 - 32'(4 * (i - 7));
            wr(pool[i], 2'd2, $urandom);
        end
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'hFFFF_BFE0 + 32'($urandom_range(0, 15));
                1:       a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: a = pool[$urandom_range(0, 15)] + 32'($urandom_range(0, 3));
            endcase
            m   = 2'($urandom_range(0, 3));
            rw  = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 15) == 0);
            d   = $urandom;
            access("rand", a, rw, m, d, 1'($urandom_range(0, 7) != 0), rst);
            if (rw) rd("rand_after_wr", {a[31:2], 2'b00}, 2'd2);
        end

        @(negedge clk);
        data_cs = 1'b0; tb_drv = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
